i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
`timescale 1ns/1ps
// I2C target: 7-bit addressed port into an external register file. A write
// sets the register pointer and then bursts data; a read streams from the pointer.
module i2c_target #(
  parameter logic [6:0] ADDRESS = 7'h6B
) (
  input  logic       clk_in,
  input  logic       RESETn,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    PTR      = 3'd3,
    DATA_WR  = 3'd4,
    WR_ACK   = 3'd5,
    DATA_RD  = 3'd6,
    RD_ACK   = 3'd7
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, scl_prev;
  logic       sda_s1, sda_s2, sda_prev;
  logic [7:0] shift_reg, tx_reg;
  logic [2:0] bit_cnt;
  logic       byte_done, rw_bit, ack_bit, sda_oe, ptr_inc;
  logic       scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0] rx_byte;

  // Open drain: only ever pull low or let the bus pull-up win.
  assign sda        = sda_oe ? 1'b0 : 1'bz;
  assign scl_rise   = scl_s2 & ~scl_prev;
  assign scl_fall   = ~scl_s2 & scl_prev;
  assign start_cond = scl_s2 & scl_prev & sda_prev & ~sda_s2;
  assign stop_cond  = scl_s2 & scl_prev & ~sda_prev & sda_s2;
  assign rx_byte    = {shift_reg[6:0], sda_s2};
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk_in) begin
    if (!RESETn) begin
      state     <= IDLE;
      scl_s1    <= 1'b1;
      scl_s2    <= 1'b1;
      scl_prev  <= 1'b1;
      sda_s1    <= 1'b1;
      sda_s2    <= 1'b1;
      sda_prev  <= 1'b1;
      shift_reg <= 8'h00;
      tx_reg    <= 8'h00;
      bit_cnt   <= 3'd0;
      byte_done <= 1'b0;
      rw_bit    <= 1'b0;
      ack_bit   <= 1'b1;
      sda_oe    <= 1'b0;
      ptr_inc   <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
    end else begin
      scl_s1   <= scl;
      scl_s2   <= scl_s1;
      scl_prev <= scl_s2;
      sda_s1   <= sda;
      sda_s2   <= sda_s1;
      sda_prev <= sda_s2;
      reg_we   <= 1'b0;
      ptr_inc  <= 1'b0;
      if (ptr_inc) reg_addr <= reg_addr + 8'd1;

      if (start_cond) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_cond) begin
        state     <= IDLE;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else begin
        case (state)
          ADDR, PTR, DATA_WR: begin
            if (scl_rise) begin
              shift_reg <= rx_byte;
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_done <= 1'b1;
                if (state == PTR) reg_addr <= rx_byte;
                if (state == DATA_WR) begin
                  reg_wdata <= rx_byte;
                  reg_we    <= 1'b1;
                  ptr_inc   <= 1'b1;
                end
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              if (state == ADDR) begin
                if (shift_reg[7:1] == ADDRESS) begin
                  sda_oe <= 1'b1;
                  rw_bit <= shift_reg[0];
                  state  <= ADDR_ACK;
                end else begin
                  state <= IDLE;
                end
              end else begin
                sda_oe <= 1'b1;
                state  <= WR_ACK;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= 3'd0;
              if (!rw_bit) begin
                sda_oe <= 1'b0;
                state  <= PTR;
              end else begin
                tx_reg  <= reg_rdata;
                sda_oe  <= ~reg_rdata[7];
                ptr_inc <= 1'b1;
                state   <= DATA_RD;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= DATA_WR;
            end
          end
          DATA_RD: begin
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                sda_oe <= 1'b0;
                state  <= RD_ACK;
              end else begin
                tx_reg <= {tx_reg[6:0], 1'b0};
                sda_oe <= ~tx_reg[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              ack_bit <= sda_s2;
            end else if (scl_fall) begin
              if (!ack_bit) begin
                tx_reg  <= reg_rdata;
                sda_oe  <= ~reg_rdata[7];
                ptr_inc <= 1'b1;
                bit_cnt <= 3'd0;
                state   <= DATA_RD;
              end else begin
                sda_oe <= 1'b0;
                state  <= IDLE;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule
